roberto_uc: RTL and testbench

ROBERTO_UC -- requirements
Module: roberto_uc

---
 rtl/roberto_pkg.sv | 33 +++
 rtl/roberto_uc_if.sv | 47 ++++
 rtl/roberto_uc_rx.sv | 71 +++++++
 rtl/roberto_uc.sv | 113 +++++++++++
 tb/tb_roberto_uc.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/roberto_pkg.sv
// roberto_pkg
// Shared definitions for the roberto_uc control unit: main and receive FSM
// state codes (also exported on the debug ports) and the last-index
// constants of the character, sensor and receive-register counters.
package roberto_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    MEDE          = 4'd2,
    ESPERA_MEDIDA = 4'd3,
    TRANSMITE     = 4'd4,
    ESPERA_TX     = 4'd5,
    PROX_CHAR     = 4'd6,
    PROX_SENSOR   = 4'd7,
    FIM           = 4'd8
  } estado_t;

  typedef enum logic [1:0] {
    R_ESPERA  = 2'd0,
    R_CARREGA = 2'd1,
    R_CONTA   = 2'd2,
    R_PULA    = 2'd3
  } estado_rx_t;

  // hundreds, tens, units, '#'
  localparam logic [1:0] ULTIMO_CHAR   = 2'd3;
  // three ultrasonic sensors
  localparam logic [1:0] ULTIMO_SENSOR = 2'd2;
  // three receive registers; index 3 is skipped
  localparam logic [1:0] ULTIMO_REG    = 2'd2;

endpackage

// File: rtl/roberto_uc_if.sv
// roberto_uc_if
// Control/status bundle between the roberto_uc control unit and its datapath
// (seconds counter, sensor/character counters, 7E1 transmitter/receiver,
// servo and receive registers).
//   master : control unit side (drives clears, enables, pulses, debug codes)
//   slave  : datapath side (drives ready pulses and counter values)
interface roberto_uc_if;
  logic       ligar;
  logic       pronto_seg;
  logic       pronto_serial;
  logic       pronto_recepcao;
  logic [1:0] Q_2;
  logic [1:0] Q_3;
  logic [1:0] Q_recepcao;

  logic       zera_sensor, zera_serial, zera_recpcao, zera_servos;
  logic       zera_seg, zera_2, zera_3;
  logic       cont_seg, cont_2, cont_3, cont_recepcao;
  logic       medir;
  logic       partida_tx;
  logic       carrega_reg_1, carrega_reg_2, carrega_reg_3;
  logic       fim_ciclo;
  logic [3:0] db_estado;
  logic [1:0] db_estado_rx;

  modport master (
    input  ligar, pronto_seg, pronto_serial, pronto_recepcao,
           Q_2, Q_3, Q_recepcao,
    output zera_sensor, zera_serial, zera_recpcao, zera_servos,
           zera_seg, zera_2, zera_3,
           cont_seg, cont_2, cont_3, cont_recepcao,
           medir, partida_tx,
           carrega_reg_1, carrega_reg_2, carrega_reg_3,
           fim_ciclo, db_estado, db_estado_rx
  );

  modport slave (
    output ligar, pronto_seg, pronto_serial, pronto_recepcao,
           Q_2, Q_3, Q_recepcao,
    input  zera_sensor, zera_serial, zera_recpcao, zera_servos,
           zera_seg, zera_2, zera_3,
           cont_seg, cont_2, cont_3, cont_recepcao,
           medir, partida_tx,
           carrega_reg_1, carrega_reg_2, carrega_reg_3,
           fim_ciclo, db_estado, db_estado_rx
  );
endinterface

// File: rtl/roberto_uc_rx.sv
// roberto_uc_rx
// Receive sequencer: each valid character from the 7E1 receiver is loaded
// into receive register Q_recepcao+1, then the index advances, skipping
// index 3 so the registers fill 1,2,3,1,...
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   habilita         1 while the main FSM is out of INICIAL
//   pronto_recepcao  character-valid pulse from the receiver
//   q_recepcao       receive register index counter value
//   cont_recepcao    index counter enable
//   carrega_reg_1..3 register load strobes
//   estado_rx        state code for debug
//
// state     | meaning
// R_ESPERA  | idle, waiting for a received character
// R_CARREGA | load the register selected by the index
// R_CONTA   | advance the index
// R_PULA    | advance once more past the unused index 3
module roberto_uc_rx
  import roberto_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       pronto_recepcao,
  input  logic [1:0] q_recepcao,
  output logic       cont_recepcao,
  output logic       carrega_reg_1,
  output logic       carrega_reg_2,
  output logic       carrega_reg_3,
  output logic [1:0] estado_rx
);

  estado_rx_t estado, prox;

  always_ff @(posedge clock) begin
    if (reset || !habilita) estado <= R_ESPERA;
    else                    estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      R_ESPERA:  if (pronto_recepcao) prox = R_CARREGA;
      R_CARREGA: prox = R_CONTA;
      R_CONTA:   prox = (q_recepcao == ULTIMO_REG) ? R_PULA : R_ESPERA;
      R_PULA:    prox = R_ESPERA;
      default:   prox = R_ESPERA;
    endcase
  end

  always_comb begin
    cont_recepcao = 1'b0;
    carrega_reg_1 = 1'b0;
    carrega_reg_2 = 1'b0;
    carrega_reg_3 = 1'b0;
    case (estado)
      R_CARREGA: begin
        carrega_reg_1 = (q_recepcao == 2'd0);
        carrega_reg_2 = (q_recepcao == 2'd1);
        carrega_reg_3 = (q_recepcao == 2'd2);
      end
      R_CONTA: cont_recepcao = 1'b1;
      R_PULA:  cont_recepcao = 1'b1;
      default: ;
    endcase
  end

  assign estado_rx = estado;

endmodule

// File: rtl/roberto_uc.sv
// roberto_uc
// Control unit of the sonar/servo station: measures with three ultrasonic
// sensors, transmits 4 characters per sensor (12 per cycle) over 7E1 serial,
// and sequences received characters into three registers.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   uc            roberto_uc_if master: datapath clears/enables/pulses,
//                 ready pulses, counter values, debug state codes
//
// state         | meaning
// INICIAL       | idle, all datapath cleared, waits for ligar
// PREPARA       | clear seconds and sensor/character counters
// MEDE          | start pulse to the ultrasonic interfaces
// ESPERA_MEDIDA | count the measurement interval until pronto_seg
// TRANSMITE     | start pulse to the transmitter
// ESPERA_TX     | wait for the transmitter done pulse
// PROX_CHAR     | next character, or move on after '#'
// PROX_SENSOR   | next sensor, or finish after the last one
// FIM           | end-of-cycle pulse; restart or go idle
module roberto_uc
  import roberto_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  roberto_uc_if.master  uc
);

  estado_t estado, prox;

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:       if (uc.ligar) prox = PREPARA;
      PREPARA:       prox = MEDE;
      MEDE:          prox = ESPERA_MEDIDA;
      ESPERA_MEDIDA: if (uc.pronto_seg) prox = TRANSMITE;
      TRANSMITE:     prox = ESPERA_TX;
      ESPERA_TX:     if (uc.pronto_serial) prox = PROX_CHAR;
      PROX_CHAR:     prox = (uc.Q_3 == ULTIMO_CHAR) ? PROX_SENSOR : TRANSMITE;
      PROX_SENSOR:   prox = (uc.Q_2 == ULTIMO_SENSOR) ? FIM : TRANSMITE;
      FIM:           prox = uc.ligar ? PREPARA : INICIAL;
      default:       prox = INICIAL;
    endcase
  end

  // Q_2/Q_3 qualifiers are registered counter values, so the enables stay
  // glitch-free and change only with the clock.
  always_comb begin
    uc.zera_sensor = 1'b0;
    uc.zera_serial = 1'b0;
    uc.zera_recpcao = 1'b0;
    uc.zera_servos = 1'b0;
    uc.zera_seg = 1'b0;
    uc.zera_2 = 1'b0;
    uc.zera_3 = 1'b0;
    uc.cont_seg = 1'b0;
    uc.cont_2 = 1'b0;
    uc.cont_3 = 1'b0;
    uc.medir = 1'b0;
    uc.partida_tx = 1'b0;
    uc.fim_ciclo = 1'b0;
    case (estado)
      INICIAL: begin
        uc.zera_sensor = 1'b1;
        uc.zera_serial = 1'b1;
        uc.zera_recpcao = 1'b1;
        uc.zera_servos = 1'b1;
        uc.zera_seg = 1'b1;
        uc.zera_2 = 1'b1;
        uc.zera_3 = 1'b1;
      end
      PREPARA: begin
        uc.zera_seg = 1'b1;
        uc.zera_2 = 1'b1;
        uc.zera_3 = 1'b1;
      end
      MEDE:          uc.medir = 1'b1;
      ESPERA_MEDIDA: uc.cont_seg = 1'b1;
      TRANSMITE:     uc.partida_tx = 1'b1;
      PROX_CHAR:     uc.cont_3 = (uc.Q_3 != ULTIMO_CHAR);
      PROX_SENSOR: begin
        uc.zera_3 = 1'b1;
        uc.cont_2 = (uc.Q_2 != ULTIMO_SENSOR);
      end
      FIM: begin
        uc.fim_ciclo = 1'b1;
        uc.zera_2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign uc.db_estado = estado;

  roberto_uc_rx u_rx (
    .clock           (clock),
    .reset           (reset),
    .habilita        (estado != INICIAL),
    .pronto_recepcao (uc.pronto_recepcao),
    .q_recepcao      (uc.Q_recepcao),
    .cont_recepcao   (uc.cont_recepcao),
    .carrega_reg_1   (uc.carrega_reg_1),
    .carrega_reg_2   (uc.carrega_reg_2),
    .carrega_reg_3   (uc.carrega_reg_3),
    .estado_rx       (uc.db_estado_rx)
  );

endmodule

// File: tb/tb_roberto_uc.sv
// tb_roberto_uc
// Bench for roberto_uc: models the datapath counters, seconds counter and
// transmitter, and checks transmit order, cycle framing and receive-register
// sequencing against the behavioural expectations.
module tb_roberto_uc;

  logic clock = 1'b0;
  logic reset = 1'b1;

  roberto_uc_if bus ();

  roberto_uc dut (
    .clock (clock),
    .reset (reset),
    .uc    (bus.master)
  );

  always #5 clock = ~clock;

  // datapath environment
  logic [1:0] q2 = 2'd0, q3 = 2'd0, qr = 2'd0;
  logic [7:0] seg_cnt = 8'd0, seg_lim = 8'd20;
  logic       ligar = 1'b0, ps_auto = 1'b0, ps_man = 1'b0, pr_rx = 1'b0;

  always @(posedge clock) begin
    if (bus.zera_2) q2 <= 2'd0; else if (bus.cont_2) q2 <= q2 + 2'd1;
    if (bus.zera_3) q3 <= 2'd0; else if (bus.cont_3) q3 <= q3 + 2'd1;
    if (bus.zera_recpcao) qr <= 2'd0; else if (bus.cont_recepcao) qr <= qr + 2'd1;
    if (bus.zera_seg) seg_cnt <= 8'd0; else if (bus.cont_seg) seg_cnt <= seg_cnt + 8'd1;
  end

  assign bus.Q_2 = q2;
  assign bus.Q_3 = q3;
  assign bus.Q_recepcao = qr;
  assign bus.pronto_seg = (seg_cnt == seg_lim);
  assign bus.ligar = ligar;
  assign bus.pronto_serial = ps_auto | ps_man;
  assign bus.pronto_recepcao = pr_rx;

  int n_checks = 0, n_err = 0;
  int exp_idx = 0, tx_pulses = 0, fim_count = 0, medir_count = 0, rx_n = 0;
  int tx_timer = 0, tx_delay = 5;
  bit tx_auto = 1'b1;
  logic [2:0] ld;
  logic [3:0] exp_pair;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // transmitter model and scoreboard, evaluated away from the active edge
  initial forever begin
    @(negedge clock);
    ps_auto = 1'b0;
    if (reset) tx_timer = 0;
    else begin
      if (tx_timer > 0) begin
        tx_timer--;
        if (tx_timer == 0 && tx_auto) ps_auto = 1'b1;
      end
      if (bus.partida_tx === 1'b1 && tx_auto) tx_timer = tx_delay;
    end
    if (bus.medir === 1'b1) begin
      check("medir_at_start", exp_idx, 0);
      medir_count++;
    end
    if (bus.partida_tx === 1'b1) begin
      exp_pair = {2'(exp_idx / 4), 2'(exp_idx % 4)};
      check("tx_order", {q2, q3}, exp_pair);
      exp_idx++;
      tx_pulses++;
    end
    if (bus.fim_ciclo === 1'b1) begin
      check("fim_after_12", exp_idx, 12);
      exp_idx = 0;
      fim_count++;
    end
    ld = {bus.carrega_reg_3, bus.carrega_reg_2, bus.carrega_reg_1};
    if ((|ld) === 1'b1) begin
      check("rx_load_reg", ld, 32'd1 << (rx_n % 3));
      check("rx_load_q", qr, rx_n % 3);
      rx_n++;
    end
  end

  task automatic wait_fim(input int target, input int budget, input string tag);
    int i = 0;
    while (fim_count < target && i < budget) begin @(negedge clock); i++; end
    check(tag, fim_count, target);
  endtask

  task automatic wait_medir(input int target, input int budget, input string tag);
    int i = 0;
    while (medir_count < target && i < budget) begin @(negedge clock); i++; end
    check(tag, medir_count, target);
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string tag);
    int i = 0;
    while (bus.db_estado !== st && i < budget) begin @(negedge clock); i++; end
    check(tag, bus.db_estado, st);
  endtask

  task automatic pulse_rx();
    pr_rx = 1'b1;
    @(negedge clock);
    pr_rx = 1'b0;
  endtask

  initial begin
    int t, mc, fc;
    // reset held
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_state", bus.db_estado, 0);
    check("rst_state_rx", bus.db_estado_rx, 0);
    check("rst_zera", {bus.zera_sensor, bus.zera_serial, bus.zera_recpcao, bus.zera_servos,
                       bus.zera_seg, bus.zera_2, bus.zera_3}, 7'h7f);
    check("rst_pulses", {bus.cont_seg, bus.cont_2, bus.cont_3, bus.cont_recepcao, bus.medir,
                         bus.partida_tx, bus.carrega_reg_1, bus.carrega_reg_2,
                         bus.carrega_reg_3, bus.fim_ciclo}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("idle_no_ligar", bus.db_estado, 0);
    check("idle_no_medir", medir_count, 0);

    // full cycle, then restart
    seg_lim = 8'd20;
    tx_delay = 5;
    ligar = 1'b1;
    wait_fim(1, 1000, "cycle1_fim");
    check("cycle1_tx", tx_pulses, 12);
    wait_medir(2, 50, "cycle2_medir");

    // drop ligar during the 5th character
    t = 0;
    while (exp_idx != 5 && t < 500) begin @(negedge clock); t++; end
    check("wait_char5", exp_idx, 5);
    ligar = 1'b0;
    wait_fim(2, 1000, "stop_fim");
    repeat (3) @(negedge clock);
    check("stop_idle", bus.db_estado, 0);
    check("stop_tx_total", tx_pulses, 24);
    repeat (50) @(negedge clock);
    check("stop_no_medir", medir_count, 2);

    // four received characters, 200 cycles apart
    rx_n = 0;
    ligar = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (200) @(negedge clock);
      pulse_rx();
    end
    repeat (5) @(negedge clock);
    check("rx_count", rx_n, 4);
    check("rx_q_end", qr, 1);

    // receive pulse coincident with transmitter done
    tx_auto = 1'b0;
    wait_state(4'd5, 600, "coin_reach_tx");
    ps_man = 1'b1;
    pr_rx = 1'b1;
    @(negedge clock);
    ps_man = 1'b0;
    pr_rx = 1'b0;
    tx_auto = 1'b1;
    check("coin_main", bus.db_estado, 6);
    check("coin_rx", bus.db_estado_rx, 1);
    @(negedge clock);
    check("coin_load", rx_n, 5);

    // reset while waiting on the transmitter
    wait_state(4'd5, 600, "abort_reach_tx");
    reset = 1'b1;
    ligar = 1'b0;
    t = tx_pulses;
    @(negedge clock);
    check("abort_state", bus.db_estado, 0);
    check("abort_zera", {bus.zera_sensor, bus.zera_serial, bus.zera_recpcao, bus.zera_servos,
                         bus.zera_seg, bus.zera_2, bus.zera_3}, 7'h7f);
    exp_idx = 0;
    rx_n = 0;
    @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    check("abort_no_tx", tx_pulses, t);
    check("abort_idle", bus.db_estado, 0);
    mc = medir_count;
    ligar = 1'b1;
    wait_medir(mc + 1, 30, "restart_medir");

    // randomized timing with concurrent reception
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          wait_fim(fim_count + 1, 3000, "rand_fim");
          seg_lim = 8'($urandom_range(3, 30));
          tx_delay = $urandom_range(1, 9);
        end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          repeat ($urandom_range(100, 160)) @(negedge clock);
          pulse_rx();
        end
      end
    join
    repeat (5) @(negedge clock);
    check("rand_rx_count", rx_n, 6);

    ligar = 1'b0;
    fc = fim_count;
    wait_fim(fc + 1, 3000, "final_fim");
    repeat (3) @(negedge clock);
    check("final_idle", bus.db_estado, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
